// File: rtl/dpd_delay_est.sv
// dpd_delay_est: measures the PA feedback loop delay by capturing a window of
// reference and feedback I/Q samples, cross-correlating them for every lag
// 0..MAX_LAG, and reporting the lag with the largest signed correlation.
module dpd_delay_est #(
  parameter int W       = 20,
  parameter int WIN     = 256,
  parameter int MAX_LAG = 63,
  localparam int DW     = $clog2(MAX_LAG + 1),
  localparam int PW     = 2 * W + 1 + $clog2(WIN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [W-1:0]  ref_i,
  input  logic signed [W-1:0]  ref_q,
  input  logic signed [W-1:0]  fb_i,
  input  logic signed [W-1:0]  fb_q,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  output logic [DW-1:0]        delay_est,
  output logic signed [PW-1:0] peak
);

  localparam int FBN = WIN + MAX_LAG;        // feedback buffer depth
  localparam int AW  = $clog2(WIN);          // reference buffer address width
  localparam int FAW = $clog2(FBN);          // feedback buffer address width
  localparam int NW  = $clog2(WIN + 3);      // per-lag phase counter width
  localparam int PRW = 2 * W;                // product width
  localparam int SW  = 2 * W + 1;            // I+Q pair sum width

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_CORR, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [FAW-1:0]        r_k;
  logic [NW-1:0]         r_n;
  logic [DW-1:0]         r_d;
  logic [2*W-1:0]        r_ref_mem [WIN];
  logic [2*W-1:0]        r_fb_mem  [FBN];
  logic [2*W-1:0]        r_ref_rd;
  logic [2*W-1:0]        r_fb_rd;
  logic                  r_v1;
  logic                  r_v2;
  logic signed [SW-1:0]  r_pair;
  logic signed [PW-1:0]  r_acc;
  logic signed [PW-1:0]  r_best;
  logic [DW-1:0]         r_best_d;

  logic                  w_cap;
  logic                  w_ref_we;
  logic                  w_rd_ok;
  logic                  w_lag_end;
  logic [AW-1:0]         w_ref_addr;
  logic [FAW-1:0]        w_fb_addr;
  logic signed [W-1:0]   w_rd_ri, w_rd_rq, w_rd_fi, w_rd_fq;
  logic signed [PRW-1:0] w_prod_i, w_prod_q;
  logic signed [SW-1:0]  w_pair;
  logic signed [PW-1:0]  w_pair_ext;
  logic                  w_best_upd;
  logic signed [PW-1:0]  w_best_val;
  logic [DW-1:0]         w_best_d;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;

  assign w_cap      = (r_state == S_CAPTURE);
  assign w_ref_we   = w_cap && (r_k < FAW'(WIN));
  assign w_rd_ok    = (r_state == S_CORR) && (r_n < NW'(WIN));
  assign w_lag_end  = (r_state == S_CORR) && (r_n == NW'(WIN + 2));
  assign w_ref_addr = r_n[AW-1:0];
  assign w_fb_addr  = w_rd_ok ? (FAW'(r_n[AW-1:0]) + FAW'(r_d)) : '0;

  assign w_rd_ri    = r_ref_rd[2*W-1:W];
  assign w_rd_rq    = r_ref_rd[W-1:0];
  assign w_rd_fi    = r_fb_rd[2*W-1:W];
  assign w_rd_fq    = r_fb_rd[W-1:0];
  assign w_prod_i   = PRW'(w_rd_ri) * PRW'(w_rd_fi);
  assign w_prod_q   = PRW'(w_rd_rq) * PRW'(w_rd_fq);
  assign w_pair     = SW'(w_prod_i) + SW'(w_prod_q);
  assign w_pair_ext = PW'(r_pair);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_CAPTURE; else w_state_nxt = S_IDLE;
      S_CAPTURE: if (r_k == FAW'(FBN - 1)) w_state_nxt = S_CORR; else w_state_nxt = S_CAPTURE;
      S_CORR:    if (w_lag_end && (r_d == DW'(MAX_LAG))) w_state_nxt = S_DONE; else w_state_nxt = S_CORR;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode: status flags for the upcoming state, registered below
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE:    begin w_busy_nxt = 1'b0; w_done_nxt = 1'b0; end
      S_CAPTURE: begin w_busy_nxt = 1'b1; w_done_nxt = 1'b0; end
      S_CORR:    begin w_busy_nxt = 1'b1; w_done_nxt = 1'b0; end
      S_DONE:    begin w_busy_nxt = 1'b1; w_done_nxt = 1'b1; end
      default:   begin w_busy_nxt = 1'b0; w_done_nxt = 1'b0; end
    endcase
  end

  // Capture index, per-lag phase counter and lag counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k <= '0;
      r_n <= '0;
      r_d <= '0;
    end else begin
      case (r_state)
        S_CAPTURE: r_k <= r_k + FAW'(1);
        S_CORR: begin
          if (w_lag_end) begin
            r_n <= '0;
            r_d <= r_d + DW'(1);
          end else begin
            r_n <= r_n + NW'(1);
          end
        end
        default: begin
          r_k <= '0;
          r_n <= '0;
          r_d <= '0;
        end
      endcase
    end
  end

  // Sample buffers (simple dual-port RAM, registered read, no reset)
  always_ff @(posedge clk) begin
    if (w_ref_we) r_ref_mem[r_k[AW-1:0]] <= {ref_i, ref_q};
    if (w_cap)    r_fb_mem[r_k]          <= {fb_i, fb_q};
    r_ref_rd <= r_ref_mem[w_ref_addr];
    r_fb_rd  <= r_fb_mem[w_fb_addr];
  end

  // Multiply-accumulate pipeline: read -> pair sum -> accumulate, cleared per lag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_pair <= '0;
      r_acc  <= '0;
    end else begin
      r_v1   <= w_rd_ok;
      r_v2   <= r_v1;
      r_pair <= w_pair;
      if (r_state != S_CORR || w_lag_end) r_acc <= '0;
      else if (r_v2)                      r_acc <= r_acc + w_pair_ext;
    end
  end

  // Peak candidate: lag 0 seeds the best value, later lags must be strictly greater
  always_comb begin
    w_best_upd = 1'b0;
    if (r_d == '0)             w_best_upd = 1'b1;
    else if (r_acc > r_best)   w_best_upd = 1'b1;
    else                       w_best_upd = 1'b0;
    w_best_val = w_best_upd ? r_acc : r_best;
    w_best_d   = w_best_upd ? r_d   : r_best_d;
  end

  // Running best correlation and its lag, updated at the end of each lag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_best   <= '0;
      r_best_d <= '0;
    end else if (w_lag_end) begin
      r_best   <= w_best_val;
      r_best_d <= w_best_d;
    end
  end

  // Registered outputs; the estimate is loaded only when entering DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      delay_est <= '0;
      peak      <= '0;
    end else begin
      busy <= w_busy_nxt;
      done <= w_done_nxt;
      if (w_done_nxt) begin
        valid     <= 1'b1;
        delay_est <= w_best_d;
        peak      <= w_best_val;
      end
    end
  end

endmodule

// File: doc/dpd_delay_est.md
DPD_DELAY_EST -- requirements
Module: dpd_delay_est

Interface
REQ-001 The block SHALL have parameter W, default 20, meaning sample width of each I/Q component, signed two's complement.
REQ-002 The block SHALL have parameter WIN, default 256, meaning correlation window length in samples, a power of two.
REQ-003 The block SHALL have parameter MAX_LAG, default 63, meaning largest loop delay searched, in clk cycles.
REQ-004 The block SHALL have port clk  input  1  clock, all logic on rising edge; the block uses this one clock only.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port start  input  1  single-cycle request to measure the loop delay.
REQ-007 The block SHALL have port ref_i / ref_q  input  W each  transmitted training sample, signed.
REQ-008 The block SHALL have port fb_i / fb_q  input  W each  PA feedback sample, signed.
REQ-009 The block SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse when a new estimate is written.
REQ-011 The block SHALL have port valid  output  1  high once an estimate exists, held until reset.
REQ-012 The block SHALL have port delay_est  output  clog2(MAX_LAG+1)  estimated loop delay in cycles.
REQ-013 The block SHALL have port peak  output  2W+1+log2(WIN)  signed correlation value at delay_est.

Function
REQ-014 The FSM SHALL have states IDLE, CAPTURE, CORR and DONE; reset enters IDLE.
REQ-015 In IDLE, start=1 SHALL move the FSM to CAPTURE on the next edge; start in any other state SHALL be ignored.
REQ-016 Capture sample index k SHALL be 0 in the first CAPTURE cycle; ref SHALL be stored for k=0..WIN-1 and fb for k=0..WIN+MAX_LAG-1.
REQ-017 CAPTURE SHALL last exactly WIN+MAX_LAG cycles, then go to CORR.
REQ-018 CORR SHALL compute, for each lag d=0..MAX_LAG in ascending order, C(d)=sum over n=0..WIN-1 of (ref_i[n]*fb_i[n+d] + ref_q[n]*fb_q[n+d]).
REQ-019 Arithmetic SHALL be full precision: each product is 2W bits, the pair sum is 2W+1 bits, and the accumulator is 2W+1+log2(WIN) bits, with no rounding or saturation.
REQ-020 Peak selection SHALL be signed; C(d) replaces the best value only if it is strictly greater, so ties keep the smallest lag.
REQ-021 The best value SHALL be initialised to C(0), not to zero, so that all-negative correlations still select a lag.
REQ-022 CORR SHALL take at most (MAX_LAG+1)*(WIN+4) cycles, which allows up to 4 cycles of pipeline and buffer-read overhead per lag.
REQ-023 In DONE, delay_est, peak and valid=1 SHALL be registered, and done SHALL be 1 for exactly that one cycle; the next state SHALL be IDLE.
REQ-024 busy SHALL be 1 in CAPTURE, CORR and DONE and 0 in IDLE.
REQ-025 delay_est and peak SHALL hold their values between measurements and SHALL change only in DONE.
REQ-026 Input samples SHALL be ignored outside CAPTURE.
REQ-027 Sample buffers SHALL be inferable as simple dual-port RAM (WIN x 2W ref, (WIN+MAX_LAG) x 2W fb) and SHALL need no reset.

Reset
REQ-028 reset=1 SHALL immediately force state=IDLE, busy=0, done=0, valid=0, delay_est=0 and peak=0, including in the middle of CAPTURE or CORR.
REQ-029 After reset release, the block SHALL accept start on the first rising edge at which reset is low.
REQ-030 A partial measurement interrupted by reset SHALL never update the outputs.

Verification
REQ-031 Bench: ref = pseudo-random +/-0x40000 I/Q, fb = ref delayed 41 cycles, start -> done within the REQ-022 bound, delay_est=41, valid=1, peak=WIN*2*0x40000^2.
REQ-032 Bench: fb = ref delayed 0, and separately fb = ref delayed 63 -> delay_est=0 and delay_est=63 respectively.
REQ-033 Bench: fb all zero -> every C(d)=0, delay_est=0, peak=0, valid=1.
REQ-034 Bench: fb = -ref delayed 10 (all C(d) <= 0) -> delay_est is the lag of maximum signed C(d), matching a reference model, and peak equals that C(d).
REQ-035 Bench: a second start pulsed 5 cycles after the first -> ignored; exactly one done pulse occurs and busy is continuous.
REQ-036 Bench: reset asserted mid-CORR after one completed run -> outputs are zero immediately, valid=0, and a new start completes normally.
